counter_timer_unit: RTL and testbench

//  Memory-mapped three-channel programmable down-counter: the peripheral responder behind the bus decoder's counter port (0xF...4).

---
 rtl/counter_timer_if.sv | 31 +++
 rtl/counter_timer_unit.sv | 134 +++++++++++++
 tb/tb_counter_timer_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/counter_timer_if.sv
// -----------------------------------------------------------------------------
// counter_timer_if
// CPU-side bus bundle between the bus decoder and the counter/timer unit.
//   counter_we     write strobe (single cycle)
//   counter_ch     target: 0..2 = channel load/count, 3 = control register
//   Peripheral_in  write data from the CPU
//   counter_out    read data returned to the CPU (same-cycle)
// master: bus decoder side; slave: counter/timer unit side.
// -----------------------------------------------------------------------------
interface counter_timer_if #(
  parameter int WIDTH = 32
);
  logic             counter_we;
  logic [1:0]       counter_ch;
  logic [WIDTH-1:0] Peripheral_in;
  logic [WIDTH-1:0] counter_out;

  modport master (
    output counter_we,
    output counter_ch,
    output Peripheral_in,
    input  counter_out
  );

  modport slave (
    input  counter_we,
    input  counter_ch,
    input  Peripheral_in,
    output counter_out
  );
endinterface

// File: rtl/counter_timer_unit.sv
// -----------------------------------------------------------------------------
// counter_timer_unit
// Three-channel programmable down-counter behind the bus decoder's counter port.
// Each channel holds a load value and a live count; tick strobes decrement the
// count and the terminal event (count at 1) drives the channel event output
// according to the channel's 2-bit mode in the control register:
//   00/11 one-shot (count stops at 0, output latched high)
//   01    rate     (reload, output high for one clock)
//   10    square   (reload, output toggles -> period of 2*load ticks)
// Ports:
//   clk            system clock, all state on the rising edge
//   rst            synchronous active-high reset
//   bus            counter_timer_if slave (write strobe, channel, data, read data)
//   tick0..tick2   per-channel count enables (every high cycle counts)
//   counter0_out..counter2_out  registered per-channel event outputs
// -----------------------------------------------------------------------------
module counter_timer_unit #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 6
) (
  input  logic           clk,
  input  logic           rst,
  counter_timer_if.slave bus,
  input  logic           tick0,
  input  logic           tick1,
  input  logic           tick2,
  output logic           counter0_out,
  output logic           counter1_out,
  output logic           counter2_out
);

  localparam logic [1:0]       MODE_RATE   = 2'b01;
  localparam logic [1:0]       MODE_SQUARE = 2'b10;
  localparam logic [WIDTH-1:0] CNT_ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [CTRL_W-1:0] ctrl_r;
  logic [CTRL_W-1:0] ctrl_nx_s;
  logic [WIDTH-1:0]  load_r    [3];
  logic [WIDTH-1:0]  cnt_r     [3];
  logic [WIDTH-1:0]  load_nx_s [3];
  logic [WIDTH-1:0]  cnt_nx_s  [3];
  logic [2:0]        evt_r;
  logic [2:0]        evt_nx_s;
  logic [2:0]        tick_s;
  logic [2:0]        wr_ch_s;
  logic              wr_ctrl_s;

  assign tick_s = {tick2, tick1, tick0};

  // Decode the write strobe into per-channel and control-register enables.
  always_comb begin
    wr_ctrl_s = bus.counter_we && (bus.counter_ch == 2'd3);
    for (int i = 0; i < 3; i++) begin
      wr_ch_s[i] = bus.counter_we && (bus.counter_ch == 2'(i));
    end
  end

  // Next-state for control, load, count and event registers.
  always_comb begin
    ctrl_nx_s = wr_ctrl_s ? bus.Peripheral_in[CTRL_W-1:0] : ctrl_r;
    for (int i = 0; i < 3; i++) begin
      load_nx_s[i] = load_r[i];
      cnt_nx_s[i]  = cnt_r[i];
      // A rate pulse lasts exactly one clock; other modes hold their output.
      evt_nx_s[i]  = (ctrl_r[2*i +: 2] == MODE_RATE) ? 1'b0 : evt_r[i];
      if (wr_ch_s[i]) begin
        // A write always beats a coincident tick on the same channel.
        load_nx_s[i] = bus.Peripheral_in;
        cnt_nx_s[i]  = bus.Peripheral_in;
        evt_nx_s[i]  = 1'b0;
      end else if (tick_s[i] && (cnt_r[i] != CNT_ZERO)) begin
        if (cnt_r[i] != CNT_ONE) begin
          cnt_nx_s[i] = cnt_r[i] - CNT_ONE;
        end else begin
          // Terminal event: the mode in force now decides the reaction, so a
          // control write mid-count only takes effect here.
          case (ctrl_r[2*i +: 2])
            MODE_RATE: begin
              cnt_nx_s[i] = load_r[i];
              evt_nx_s[i] = 1'b1;
            end
            MODE_SQUARE: begin
              cnt_nx_s[i] = load_r[i];
              evt_nx_s[i] = ~evt_r[i];
            end
            default: begin
              cnt_nx_s[i] = CNT_ZERO;
              evt_nx_s[i] = 1'b1;
            end
          endcase
        end
      end else begin
        // Idle (count 0) or no tick: count holds, no wrap to all-ones.
        cnt_nx_s[i] = cnt_r[i];
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_r <= {CTRL_W{1'b0}};
      evt_r  <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        load_r[i] <= CNT_ZERO;
        cnt_r[i]  <= CNT_ZERO;
      end
    end else begin
      ctrl_r <= ctrl_nx_s;
      evt_r  <= evt_nx_s;
      for (int i = 0; i < 3; i++) begin
        load_r[i] <= load_nx_s[i];
        cnt_r[i]  <= cnt_nx_s[i];
      end
    end
  end

  // Same-cycle CPU read mux: live count or zero-extended control word.
  always_comb begin
    case (bus.counter_ch)
      2'd0:    bus.counter_out = cnt_r[0];
      2'd1:    bus.counter_out = cnt_r[1];
      2'd2:    bus.counter_out = cnt_r[2];
      2'd3:    bus.counter_out = {{(WIDTH-CTRL_W){1'b0}}, ctrl_r};
      default: bus.counter_out = CNT_ZERO;
    endcase
  end

  assign counter0_out = evt_r[0];
  assign counter1_out = evt_r[1];
  assign counter2_out = evt_r[2];

endmodule

// File: tb/tb_counter_timer_unit.sv
// -----------------------------------------------------------------------------
// tb_counter_timer_unit
// Directed scenarios followed by randomized traffic, checked against a
// tick-count reference model: each channel remembers its load value and how
// many ticks it has counted since that load, and the expected count/output is
// derived arithmetically (modulo / division) from those two numbers.
// -----------------------------------------------------------------------------
`timescale 1ns/100ps
module tb_counter_timer_unit;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst;
  logic tick0, tick1, tick2;
  logic c0, c1, c2;

  counter_timer_if #(.WIDTH(WIDTH)) bus ();

  counter_timer_unit #(.WIDTH(WIDTH), .CTRL_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .tick0        (tick0),
    .tick1        (tick1),
    .tick2        (tick2),
    .counter0_out (c0),
    .counter1_out (c1),
    .counter2_out (c2)
  );

  always #10 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  int unsigned m_ld [3];
  int unsigned m_tk [3];
  bit          m_pulse [3];
  bit [5:0]    m_ctrl;

  function automatic bit [1:0] m_mode(int i);
    return m_ctrl[2*i +: 2];
  endfunction

  function automatic int unsigned m_cnt(int i);
    if (m_ld[i] == 0) return 0;
    if (m_mode(i) == 2'b01 || m_mode(i) == 2'b10) return m_ld[i] - (m_tk[i] % m_ld[i]);
    return (m_tk[i] >= m_ld[i]) ? 0 : m_ld[i] - m_tk[i];
  endfunction

  function automatic bit m_out(int i);
    if (m_ld[i] == 0) return 1'b0;
    case (m_mode(i))
      2'b01:   return m_pulse[i];
      2'b10:   return ((m_tk[i] / m_ld[i]) % 2) == 1;
      default: return m_tk[i] >= m_ld[i];
    endcase
  endfunction

  task automatic model_edge(input bit r, input bit we, input logic [1:0] ch,
                            input logic [31:0] d, input logic [2:0] tk);
    int unsigned c;
    if (r) begin
      for (int i = 0; i < 3; i++) begin
        m_ld[i] = 0; m_tk[i] = 0; m_pulse[i] = 1'b0;
      end
      m_ctrl = 6'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        c = m_cnt(i);
        m_pulse[i] = 1'b0;
        if (we && ch == 2'(i)) begin
          m_ld[i] = d; m_tk[i] = 0;
        end else if (tk[i] && c != 0) begin
          m_tk[i]++;
          if (m_mode(i) == 2'b01 && (m_tk[i] % m_ld[i]) == 0) m_pulse[i] = 1'b1;
        end
      end
      if (we && ch == 2'd3) m_ctrl = d[5:0];
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic rd(input logic [1:0] ch, output logic [31:0] v);
    bus.counter_ch = ch;
    #1;
    v = bus.counter_out;
  endtask

  task automatic compare_all();
    logic [31:0] v;
    check("out0", {31'd0, c0}, {31'd0, m_out(0)});
    check("out1", {31'd0, c1}, {31'd0, m_out(1)});
    check("out2", {31'd0, c2}, {31'd0, m_out(2)});
    for (int i = 0; i < 3; i++) begin
      rd(2'(i), v);
      check($sformatf("cnt%0d", i), v, m_cnt(i));
    end
    rd(2'd3, v);
    check("ctrl", v, {26'd0, m_ctrl});
  endtask

  // One clock: drive at negedge, model at posedge, compare just after.
  task automatic step(input bit r, input bit we, input logic [1:0] ch,
                      input logic [31:0] d, input logic [2:0] tk);
    @(negedge clk);
    rst = r; bus.counter_we = we; bus.counter_ch = ch; bus.Peripheral_in = d;
    {tick2, tick1, tick0} = tk;
    @(posedge clk);
    model_edge(r, we, ch, d, tk);
    #1;
    bus.counter_we = 1'b0;
    compare_all();
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 2'd0, 32'd0, 3'b000);
  endtask

  initial begin
    logic [31:0] v;
    rst = 1'b1; bus.counter_we = 1'b0; bus.counter_ch = 2'd0; bus.Peripheral_in = 32'd0;
    tick0 = 1'b0; tick1 = 1'b0; tick2 = 1'b0;

    // 1: reset state, then one-shot ch0=3 with tick held high
    do_reset();
    rd(2'd0, v); check("reset_read", v, 32'd0);
    step(1'b0, 1'b1, 2'd3, 32'h0, 3'b000);
    step(1'b0, 1'b1, 2'd0, 32'd3, 3'b000);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 2'd0, 32'd0, 3'b001);
    check("oneshot_evt", {31'd0, c0}, 32'd1);
    step(1'b0, 1'b0, 2'd0, 32'd0, 3'b001);
    rd(2'd0, v); check("oneshot_nowrap", v, 32'd0);

    // 2: ch1 rate mode, load 4, continuous ticks
    do_reset();
    step(1'b0, 1'b1, 2'd3, 32'h04, 3'b000);
    step(1'b0, 1'b1, 2'd1, 32'd4, 3'b000);
    for (int k = 0; k < 9; k++) step(1'b0, 1'b0, 2'd0, 32'd0, 3'b010);

    // 3: ch2 square wave, load 2
    do_reset();
    step(1'b0, 1'b1, 2'd3, 32'h20, 3'b000);
    step(1'b0, 1'b1, 2'd2, 32'd2, 3'b000);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 2'd0, 32'd0, 3'b100);

    // 4: write and tick on the same channel in the same cycle
    do_reset();
    step(1'b0, 1'b1, 2'd0, 32'd7, 3'b000);
    step(1'b0, 1'b0, 2'd0, 32'd0, 3'b001);
    step(1'b0, 1'b0, 2'd0, 32'd0, 3'b001);
    step(1'b0, 1'b1, 2'd0, 32'd9, 3'b001);
    rd(2'd0, v); check("write_wins", v, 32'd9);
    check("write_clears", {31'd0, c0}, 32'd0);

    // 5: control readback and live count read
    do_reset();
    step(1'b0, 1'b1, 2'd3, 32'h04, 3'b000);
    step(1'b0, 1'b1, 2'd1, 32'd6, 3'b000);
    step(1'b0, 1'b0, 2'd0, 32'd0, 3'b010);
    step(1'b0, 1'b1, 2'd3, 32'h15, 3'b010);
    rd(2'd3, v); check("ctrl_read", v, 32'h0000_0015);
    rd(2'd1, v); check("live_cnt", v, 32'd4);

    // mode change mid-count: rate -> one-shot before the terminal event
    do_reset();
    step(1'b0, 1'b1, 2'd3, 32'h04, 3'b000);
    step(1'b0, 1'b1, 2'd1, 32'd3, 3'b000);
    step(1'b0, 1'b0, 2'd0, 32'd0, 3'b010);
    step(1'b0, 1'b1, 2'd3, 32'h00, 3'b000);
    rd(2'd1, v); check("ctrl_no_disturb", v, 32'd2);
    step(1'b0, 1'b0, 2'd0, 32'd0, 3'b010);
    step(1'b0, 1'b0, 2'd0, 32'd0, 3'b010);
    rd(2'd1, v); check("newmode_cnt", v, 32'd0);
    check("newmode_evt", {31'd0, c1}, 32'd1);

    // load of zero idles the channel
    step(1'b0, 1'b1, 2'd1, 32'd0, 3'b010);
    step(1'b0, 1'b0, 2'd0, 32'd0, 3'b010);
    rd(2'd1, v); check("load0_idle", v, 32'd0);

    // 6: reset mid-count on all channels with ticks high
    do_reset();
    step(1'b0, 1'b1, 2'd3, 32'h24, 3'b000);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'(i), 32'd5, 3'b000);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 2'd0, 32'd0, 3'b111);
    step(1'b1, 1'b0, 2'd0, 32'd0, 3'b111);
    check("rst_evts", {29'd0, c2, c1, c0}, 32'd0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 2'd0, 32'd0, 3'b111);

    // Randomized traffic, one control setting per round
    for (int r = 0; r < 4; r++) begin
      do_reset();
      step(1'b0, 1'b1, 2'd3, 32'($urandom_range(63, 0)), 3'b000);
      for (int k = 0; k < 200; k++) begin
        step(1'b0, ($urandom_range(5, 0) == 0), 2'($urandom_range(2, 0)),
             32'($urandom_range(5, 0)),
             {($urandom_range(3, 0) != 0), ($urandom_range(3, 0) != 0), ($urandom_range(3, 0) != 0)});
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
